// File: rtl/alu_ctrl_if.sv
// Request/response bundle between main control and the ALU-control sequencer.
// master = requester side, slave = alu_ctrl_seq side.
interface alu_ctrl_if #(
  parameter int unsigned CNT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [5:0]       func;
  logic [1:0]       imm_sel;
  logic             flush;
  logic             out_valid;
  logic [3:0]       alu_ctr;
  logic             illegal;
  logic             md_busy;
  logic             md_step;
  logic [CNT_W-1:0] md_cnt;
  logic             hilo_we;

  modport master (
    output in_valid, alu_op, func, imm_sel, flush,
    input  in_ready, out_valid, alu_ctr, illegal, md_busy, md_step, md_cnt, hilo_we
  );

  modport slave (
    input  in_valid, alu_op, func, imm_sel, flush,
    output in_ready, out_valid, alu_ctr, illegal, md_busy, md_step, md_cnt, hilo_we
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered ALU-control decoder with a multi-cycle MULT/DIV sequencer.
// All outputs are registered; in_ready mirrors state==IDLE one cycle late-free (loaded from next state).
module alu_ctrl_seq #(
  parameter int unsigned MD_CYCLES = 32,
  parameter int unsigned CNT_W     = $clog2(MD_CYCLES),
  parameter logic [3:0]  ILL_CODE  = 4'b1111
) (
  input logic       clk,
  input logic       rst_n,
  alu_ctrl_if.slave bus
);

  localparam logic [3:0] C_AND   = 4'b0000;
  localparam logic [3:0] C_OR    = 4'b0001;
  localparam logic [3:0] C_ADD   = 4'b0010;
  localparam logic [3:0] C_XOR   = 4'b0011;
  localparam logic [3:0] C_SLL   = 4'b0100;
  localparam logic [3:0] C_SRL   = 4'b0101;
  localparam logic [3:0] C_SUB   = 4'b0110;
  localparam logic [3:0] C_SLT   = 4'b0111;
  localparam logic [3:0] C_SLTU  = 4'b1000;
  localparam logic [3:0] C_SRA   = 4'b1001;
  localparam logic [3:0] C_MULT  = 4'b1010;
  localparam logic [3:0] C_MULTU = 4'b1011;
  localparam logic [3:0] C_NOR   = 4'b1100;
  localparam logic [3:0] C_DIV   = 4'b1101;
  localparam logic [3:0] C_DIVU  = 4'b1110;

  typedef enum logic [1:0] {IDLE, MD_RUN, MD_DONE} state_t;

  state_t           state, next_state;
  logic             ready_q, ov_q, ill_q, busy_q, step_q, hilo_q;
  logic [3:0]       ctr_q;
  logic [CNT_W-1:0] cnt_q;

  logic             ready_d, ov_d, ill_d, busy_d, step_d, hilo_d;
  logic [3:0]       ctr_d;
  logic [CNT_W-1:0] cnt_d;

  logic       accept;
  logic [3:0] dec_code;
  logic       dec_ill;
  logic       dec_md;

  assign accept = bus.in_valid & ready_q;

  // Combinational decode of the presented request.
  always_comb begin
    dec_code = ILL_CODE;
    dec_ill  = 1'b0;
    dec_md   = 1'b0;
    case (bus.alu_op)
      2'b00: dec_code = C_ADD;
      2'b01: dec_code = C_SUB;
      2'b10: begin
        case (bus.func)
          6'b000000: dec_code = C_SLL;
          6'b000010: dec_code = C_SRL;
          6'b000011: dec_code = C_SRA;
          6'b011000: begin dec_code = C_MULT;  dec_md = 1'b1; end
          6'b011001: begin dec_code = C_MULTU; dec_md = 1'b1; end
          6'b011010: begin dec_code = C_DIV;   dec_md = 1'b1; end
          6'b011011: begin dec_code = C_DIVU;  dec_md = 1'b1; end
          6'b100000,
          6'b100001: dec_code = C_ADD;
          6'b100010,
          6'b100011: dec_code = C_SUB;
          6'b100100: dec_code = C_AND;
          6'b100101: dec_code = C_OR;
          6'b100110: dec_code = C_XOR;
          6'b100111: dec_code = C_NOR;
          6'b101010: dec_code = C_SLT;
          6'b101011: dec_code = C_SLTU;
          default:   dec_ill  = 1'b1;
        endcase
      end
      default: begin
        case (bus.imm_sel)
          2'b00:   dec_code = C_AND;
          2'b01:   dec_code = C_OR;
          2'b10:   dec_code = C_XOR;
          default: dec_code = C_SLT;
        endcase
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      ov_q    <= 1'b0;
      ill_q   <= 1'b0;
      busy_q  <= 1'b0;
      step_q  <= 1'b0;
      hilo_q  <= 1'b0;
      ctr_q   <= 4'b0000;
      cnt_q   <= '0;
    end else begin
      state   <= next_state;
      ready_q <= ready_d;
      ov_q    <= ov_d;
      ill_q   <= ill_d;
      busy_q  <= busy_d;
      step_q  <= step_d;
      hilo_q  <= hilo_d;
      ctr_q   <= ctr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; flush wins over every transition.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && !bus.flush && dec_md) next_state = MD_RUN;
      MD_RUN: begin
        if (bus.flush)          next_state = IDLE;
        else if (cnt_q == '0)   next_state = MD_DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Next output values; alu_ctr holds unless a new code is produced.
  always_comb begin
    ready_d = (next_state == IDLE);
    ov_d    = 1'b0;
    ill_d   = 1'b0;
    busy_d  = 1'b0;
    step_d  = 1'b0;
    hilo_d  = 1'b0;
    ctr_d   = ctr_q;
    cnt_d   = '0;
    case (state)
      IDLE: begin
        if (accept && !bus.flush) begin
          ctr_d = dec_code;
          if (dec_md) begin
            busy_d = 1'b1;
            step_d = 1'b1;
            cnt_d  = CNT_W'(MD_CYCLES - 1);
          end else begin
            ov_d  = 1'b1;
            ill_d = dec_ill;
          end
        end
      end
      MD_RUN: begin
        if (!bus.flush) begin
          busy_d = 1'b1;
          if (cnt_q == '0) begin
            ov_d   = 1'b1;
            hilo_d = 1'b1;
          end else begin
            step_d = 1'b1;
            cnt_d  = cnt_q - CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = ov_q;
  assign bus.illegal   = ill_q;
  assign bus.alu_ctr   = ctr_q;
  assign bus.md_busy   = busy_q;
  assign bus.md_step   = step_q;
  assign bus.md_cnt    = cnt_q;
  assign bus.hilo_we   = hilo_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: decode sweep, MULT/DIV sequencing, flush and reset abort.
// A second instance with MD_CYCLES=2 exercises the shortest legal sequence.
module tb_alu_ctrl_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_ctrl_if #(.CNT_W(5)) ifa ();
  alu_ctrl_if #(.CNT_W(1)) ifb ();

  alu_ctrl_seq #(.MD_CYCLES(32)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  alu_ctrl_seq #(.MD_CYCLES(2))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  typedef struct {
    logic [5:0] f;
    logic [3:0] c;
  } rvec_t;

  rvec_t rtab [13] = '{
    '{6'b000000, 4'b0100}, '{6'b000010, 4'b0101}, '{6'b000011, 4'b1001},
    '{6'b100000, 4'b0010}, '{6'b100001, 4'b0010}, '{6'b100010, 4'b0110},
    '{6'b100011, 4'b0110}, '{6'b100100, 4'b0000}, '{6'b100101, 4'b0001},
    '{6'b100110, 4'b0011}, '{6'b100111, 4'b1100}, '{6'b101010, 4'b0111},
    '{6'b101011, 4'b1000}
  };

  logic [3:0] imm_exp [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_a_quiet(input string tag);
    chk({tag, ".in_ready"},  32'(ifa.in_ready),  32'd0);
    chk({tag, ".out_valid"}, 32'(ifa.out_valid), 32'd0);
    chk({tag, ".illegal"},   32'(ifa.illegal),   32'd0);
    chk({tag, ".md_busy"},   32'(ifa.md_busy),   32'd0);
    chk({tag, ".md_step"},   32'(ifa.md_step),   32'd0);
    chk({tag, ".hilo_we"},   32'(ifa.hilo_we),   32'd0);
    chk({tag, ".alu_ctr"},   32'(ifa.alu_ctr),   32'd0);
    chk({tag, ".md_cnt"},    32'(ifa.md_cnt),    32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    ifa.in_valid = 1'b0; ifa.alu_op = 2'b00; ifa.func = 6'd0; ifa.imm_sel = 2'b00; ifa.flush = 1'b0;
    ifb.in_valid = 1'b0; ifb.alu_op = 2'b00; ifb.func = 6'd0; ifb.imm_sel = 2'b00; ifb.flush = 1'b0;

    // T1 reset
    tick();
    tick();
    chk_a_quiet("reset");
    rst_n = 1'b1;
    tick();
    chk("rel.in_ready", 32'(ifa.in_ready), 32'd1);
    chk("rel.out_valid", 32'(ifa.out_valid), 32'd0);

    // T2 R-type sweep, back-to-back
    ifa.alu_op = 2'b10;
    ifa.in_valid = 1'b1;
    for (int i = 0; i < 13; i++) begin
      ifa.func = rtab[i].f;
      tick();
      chk($sformatf("rt%0d.out_valid", i), 32'(ifa.out_valid), 32'd1);
      chk($sformatf("rt%0d.alu_ctr", i),   32'(ifa.alu_ctr),   32'(rtab[i].c));
      chk($sformatf("rt%0d.illegal", i),   32'(ifa.illegal),   32'd0);
    end
    ifa.func = 6'b101111;
    tick();
    chk("ill.out_valid", 32'(ifa.out_valid), 32'd1);
    chk("ill.alu_ctr",   32'(ifa.alu_ctr),   32'hF);
    chk("ill.illegal",   32'(ifa.illegal),   32'd1);
    ifa.in_valid = 1'b0;
    tick();
    chk("idle.out_valid", 32'(ifa.out_valid), 32'd0);
    chk("idle.illegal",   32'(ifa.illegal),   32'd0);
    chk("idle.alu_ctr_hold", 32'(ifa.alu_ctr), 32'hF);

    // T3 immediates and alu_op defaults, back-to-back
    ifa.in_valid = 1'b1;
    ifa.alu_op = 2'b11;
    for (int i = 0; i < 4; i++) begin
      ifa.imm_sel = 2'(i);
      tick();
      chk($sformatf("imm%0d.out_valid", i), 32'(ifa.out_valid), 32'd1);
      chk($sformatf("imm%0d.alu_ctr", i),   32'(ifa.alu_ctr),   32'(imm_exp[i]));
    end
    ifa.alu_op = 2'b00;
    tick();
    chk("op00.alu_ctr", 32'(ifa.alu_ctr), 32'b0010);
    chk("op00.out_valid", 32'(ifa.out_valid), 32'd1);
    ifa.alu_op = 2'b01;
    tick();
    chk("op01.alu_ctr", 32'(ifa.alu_ctr), 32'b0110);
    chk("op01.out_valid", 32'(ifa.out_valid), 32'd1);

    // T4 MULT, 32 iterations; an ADD request is held while busy
    ifa.alu_op = 2'b10;
    ifa.func = 6'b011000;
    tick();
    ifa.alu_op = 2'b00;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("mult%0d.md_step", i),   32'(ifa.md_step),   32'd1);
      chk($sformatf("mult%0d.md_cnt", i),    32'(ifa.md_cnt),    32'(31 - i));
      chk($sformatf("mult%0d.md_busy", i),   32'(ifa.md_busy),   32'd1);
      chk($sformatf("mult%0d.in_ready", i),  32'(ifa.in_ready),  32'd0);
      chk($sformatf("mult%0d.out_valid", i), 32'(ifa.out_valid), 32'd0);
      chk($sformatf("mult%0d.hilo_we", i),   32'(ifa.hilo_we),   32'd0);
      tick();
    end
    chk("mdone.hilo_we",   32'(ifa.hilo_we),   32'd1);
    chk("mdone.out_valid", 32'(ifa.out_valid), 32'd1);
    chk("mdone.alu_ctr",   32'(ifa.alu_ctr),   32'b1010);
    chk("mdone.illegal",   32'(ifa.illegal),   32'd0);
    chk("mdone.md_step",   32'(ifa.md_step),   32'd0);
    chk("mdone.md_busy",   32'(ifa.md_busy),   32'd1);
    chk("mdone.in_ready",  32'(ifa.in_ready),  32'd0);
    tick();
    chk("mpost.in_ready",  32'(ifa.in_ready),  32'd1);
    chk("mpost.out_valid", 32'(ifa.out_valid), 32'd0);
    chk("mpost.hilo_we",   32'(ifa.hilo_we),   32'd0);
    chk("mpost.md_busy",   32'(ifa.md_busy),   32'd0);
    tick();
    ifa.in_valid = 1'b0;
    chk("held.out_valid", 32'(ifa.out_valid), 32'd1);
    chk("held.alu_ctr",   32'(ifa.alu_ctr),   32'b0010);

    // T5 flush DIV at md_cnt=10
    ifa.alu_op = 2'b10;
    ifa.func = 6'b011010;
    ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    chk("div.alu_ctr", 32'(ifa.alu_ctr), 32'b1101);
    repeat (21) tick();
    chk("div.md_cnt10", 32'(ifa.md_cnt), 32'd10);
    ifa.flush = 1'b1;
    tick();
    ifa.flush = 1'b0;
    chk("flush.md_busy",   32'(ifa.md_busy),   32'd0);
    chk("flush.md_step",   32'(ifa.md_step),   32'd0);
    chk("flush.in_ready",  32'(ifa.in_ready),  32'd1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("flush%0d.hilo_we", i),   32'(ifa.hilo_we),   32'd0);
      chk($sformatf("flush%0d.out_valid", i), 32'(ifa.out_valid), 32'd0);
      tick();
    end
    ifa.alu_op = 2'b00;
    ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    chk("fadd.out_valid", 32'(ifa.out_valid), 32'd1);
    chk("fadd.alu_ctr",   32'(ifa.alu_ctr),   32'b0010);
    // flush in IDLE drops the same-cycle request
    ifa.alu_op = 2'b01;
    ifa.in_valid = 1'b1;
    ifa.flush = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    ifa.flush = 1'b0;
    chk("fdrop.out_valid", 32'(ifa.out_valid), 32'd0);
    chk("fdrop.alu_ctr",   32'(ifa.alu_ctr),   32'b0010);

    // T6 reset mid-DIVU at md_cnt=5
    ifa.alu_op = 2'b10;
    ifa.func = 6'b011011;
    ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    repeat (26) tick();
    chk("divu.md_cnt5", 32'(ifa.md_cnt), 32'd5);
    rst_n = 1'b0;
    tick();
    chk_a_quiet("rstmid");
    rst_n = 1'b1;
    for (int i = 0; i < 34; i++) begin
      tick();
      chk($sformatf("rpost%0d.hilo_we", i), 32'(ifa.hilo_we), 32'd0);
    end
    chk("rpost.in_ready", 32'(ifa.in_ready), 32'd1);

    // MD_CYCLES=2 instance, MULTU
    ifb.alu_op = 2'b10;
    ifb.func = 6'b011001;
    ifb.in_valid = 1'b1;
    tick();
    ifb.in_valid = 1'b0;
    chk("b0.md_step", 32'(ifb.md_step), 32'd1);
    chk("b0.md_cnt",  32'(ifb.md_cnt),  32'd1);
    tick();
    chk("b1.md_step", 32'(ifb.md_step), 32'd1);
    chk("b1.md_cnt",  32'(ifb.md_cnt),  32'd0);
    tick();
    chk("b2.md_step",   32'(ifb.md_step),   32'd0);
    chk("b2.hilo_we",   32'(ifb.hilo_we),   32'd1);
    chk("b2.out_valid", 32'(ifb.out_valid), 32'd1);
    chk("b2.alu_ctr",   32'(ifb.alu_ctr),   32'b1011);
    tick();
    chk("b3.md_step",  32'(ifb.md_step),  32'd0);
    chk("b3.hilo_we",  32'(ifb.hilo_we),  32'd0);
    chk("b3.in_ready", 32'(ifb.in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
